// File: rtl/mem_stage.sv
// Memory-access pipeline stage: loads/stores over a single-outstanding req/ack bus, ALU/branch pass-through.
// Optional MEM_MISALIGN_TRAP_EN: flag misaligned accesses on misalign_o instead of forcing natural alignment.
module mem_stage (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [63:0] res_i,
   input  logic        wb_en_i,
   input  logic [4:0]  rd_i,
   input  logic        load_flag_i,
   input  logic        mem_en_i,
   input  logic [2:0]  mem_para_i,
   input  logic [63:0] store_value_i,
   input  logic        branch_flag_i,
   input  logic [63:0] branch_offset_i,
   input  logic [63:0] PC_i,
   output logic        stall_o,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   output logic [7:0]  dmem_wstrb,
   input  logic [63:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        wb_en_o,
   output logic [4:0]  wb_rd_o,
   output logic [63:0] wb_data_o,
   output logic        redirect_o,
   output logic [63:0] redirect_pc_o,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic        misalign_o,
`endif
   output logic        dbg_state
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]  state;
   logic [2:0]  para_q;
   logic [2:0]  off_q;
   logic [4:0]  rd_q;

   logic [1:0]  size_sel;
   logic [2:0]  align_mask;
   logic [2:0]  eff_off;
   logic [7:0]  strb_base;
   logic        trap;
   logic [63:0] lane;
   logic [63:0] load_data;

   assign dbg_state = state;

   // Size code 0..3 = 1/2/4/8 bytes; undefined codes collapse onto doubleword.
   always_comb begin
      size_sel = mem_para_i[1:0];
      if (!load_flag_i && mem_para_i[2])
         size_sel = 2'd3;
      case (size_sel)
         2'd0:    begin align_mask = 3'b111; strb_base = 8'h01; end
         2'd1:    begin align_mask = 3'b110; strb_base = 8'h03; end
         2'd2:    begin align_mask = 3'b100; strb_base = 8'h0F; end
         default: begin align_mask = 3'b000; strb_base = 8'hFF; end
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign eff_off = res_i[2:0];
   assign trap    = mem_en_i && ((res_i[2:0] & ~align_mask) != 3'b000);
`else
   assign eff_off = res_i[2:0] & align_mask;
   assign trap    = 1'b0;
`endif

   always_comb begin
      lane = dmem_rdata >> {off_q, 3'b000};
      case (para_q)
         3'd0:    load_data = {{56{lane[7]}},  lane[7:0]};
         3'd1:    load_data = {{48{lane[15]}}, lane[15:0]};
         3'd2:    load_data = {{32{lane[31]}}, lane[31:0]};
         3'd4:    load_data = {56'd0, lane[7:0]};
         3'd5:    load_data = {48'd0, lane[15:0]};
         3'd6:    load_data = {32'd0, lane[31:0]};
         default: load_data = lane;
      endcase
   end

   assign stall_o = (state == IDLE) ? (mem_en_i && !trap) : !dmem_ack;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= IDLE;
         para_q        <= 3'd0;
         off_q         <= 3'd0;
         rd_q          <= 5'd0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= 64'd0;
         dmem_wdata    <= 64'd0;
         dmem_wstrb    <= 8'd0;
         wb_en_o       <= 1'b0;
         wb_rd_o       <= 5'd0;
         wb_data_o     <= 64'd0;
         redirect_o    <= 1'b0;
         redirect_pc_o <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_en_i && !trap) begin
                  para_q     <= mem_para_i;
                  off_q      <= eff_off;
                  rd_q       <= rd_i;
                  dmem_req   <= 1'b1;
                  dmem_we    <= !load_flag_i;
                  dmem_addr  <= {res_i[63:3], 3'b000};
                  dmem_wdata <= store_value_i << {eff_off, 3'b000};
                  dmem_wstrb <= strb_base << eff_off;
                  wb_en_o    <= 1'b0;
                  redirect_o <= 1'b0;
                  state      <= BUSY;
               end else if (mem_en_i) begin
                  wb_en_o    <= 1'b0;
                  redirect_o <= 1'b0;
               end else begin
                  wb_en_o       <= wb_en_i;
                  wb_rd_o       <= rd_i;
                  wb_data_o     <= res_i;
                  redirect_o    <= branch_flag_i & res_i[0];
                  redirect_pc_o <= PC_i + branch_offset_i;
               end
            end
            default: begin
               redirect_o <= 1'b0;
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  state    <= IDLE;
                  if (!dmem_we) begin
                     wb_en_o   <= (rd_q != 5'd0);
                     wb_rd_o   <= rd_q;
                     wb_data_o <= load_data;
                  end else begin
                     wb_en_o <= 1'b0;
                  end
               end else begin
                  wb_en_o <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         misalign_o <= 1'b0;
      else
         misalign_o <= (state == IDLE) && trap;
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed test-plan steps plus randomized ALU/load/store traffic against a byte-level model.
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [63:0] res_i;
   logic        wb_en_i;
   logic [4:0]  rd_i;
   logic        load_flag_i;
   logic        mem_en_i;
   logic [2:0]  mem_para_i;
   logic [63:0] store_value_i;
   logic        branch_flag_i;
   logic [63:0] branch_offset_i;
   logic [63:0] PC_i;
   logic        stall_o;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic [63:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_en_o;
   logic [4:0]  wb_rd_o;
   logic [63:0] wb_data_o;
   logic        redirect_o;
   logic [63:0] redirect_pc_o;
   logic        dbg_state;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   mem_stage dut (
      .CLK(CLK), .RST_N(RST_N), .res_i(res_i), .wb_en_i(wb_en_i), .rd_i(rd_i),
      .load_flag_i(load_flag_i), .mem_en_i(mem_en_i), .mem_para_i(mem_para_i),
      .store_value_i(store_value_i), .branch_flag_i(branch_flag_i),
      .branch_offset_i(branch_offset_i), .PC_i(PC_i), .stall_o(stall_o),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .wb_en_o(wb_en_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
      .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
`ifdef MEM_MISALIGN_TRAP_EN
      .misalign_o(misalign_o),
`endif
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // reference model: access width in bytes from funct3
   function automatic int nbytes(input logic load, input logic [2:0] p);
      if (load) begin
         case (p)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            default:    return 8;
         endcase
      end
      if (p == 3'd0) return 1;
      if (p == 3'd1) return 2;
      if (p == 3'd2) return 4;
      return 8;
   endfunction

   function automatic int eff_offset(input logic [63:0] addr, input int n);
      int off;
      off = int'(addr % 64'd8);
      return off - (off % n);
   endfunction

   function automatic logic [63:0] exp_load(input logic [63:0] rdata, input logic [63:0] addr,
                                            input logic [2:0] p);
      int n;
      int eff;
      logic [63:0] v;
      n = nbytes(1'b1, p);
      eff = eff_offset(addr, n);
      v = 64'd0;
      for (int k = 0; k < n; k++)
         v = v | (((rdata >> (8 * (eff + k))) & 64'hFF) << (8 * k));
      if (p < 3'd3 && n < 8 && v[8*n-1])
         v = v - (64'd1 << (8 * n));
      return v;
   endfunction

   function automatic logic [63:0] exp_strb(input logic [63:0] addr, input logic [2:0] p);
      int n;
      n = nbytes(1'b0, p);
      return (((64'd1 << n) - 64'd1) << eff_offset(addr, n)) & 64'hFF;
   endfunction

   function automatic logic [63:0] exp_wdata(input logic [63:0] sv, input logic [63:0] addr,
                                             input logic [2:0] p);
      return sv * (64'd1 << (8 * eff_offset(addr, nbytes(1'b0, p))));
   endfunction

   // driver: non-memory instruction
   task automatic alu_op(input logic wb, input logic [4:0] rd, input logic [63:0] res,
                         input logic br, input logic [63:0] pc, input logic [63:0] boff);
      mem_en_i = 1'b0; wb_en_i = wb; rd_i = rd; res_i = res;
      branch_flag_i = br; PC_i = pc; branch_offset_i = boff; dmem_ack = 1'b0;
      #1;
      chk("alu_stall", stall_o, 0);
      step();
      chk("alu_wb_en", wb_en_o, wb);
      chk("alu_wb_rd", wb_rd_o, rd);
      chk("alu_wb_data", wb_data_o, res);
      chk("alu_redirect", redirect_o, br & res[0]);
      chk("alu_redirect_pc", redirect_pc_o, pc + boff);
      chk("alu_no_req", dmem_req, 0);
   endtask

   // driver + bus responder: one memory access with a given number of wait cycles
   task automatic mem_op(input logic load, input logic [2:0] p, input logic [63:0] addr,
                         input logic [63:0] sv, input logic [4:0] rd, input logic [63:0] rdata,
                         input int waits);
      int stall_cycles;
      int n;
      logic [63:0] exp_v;
      n = nbytes(load, p);
      mem_en_i = 1'b1; load_flag_i = load; mem_para_i = p; res_i = addr;
      store_value_i = sv; rd_i = rd; wb_en_i = 1'($urandom_range(0, 1));
      branch_flag_i = 1'($urandom_range(0, 1)); dmem_ack = 1'b0;
      #1;
`ifdef MEM_MISALIGN_TRAP_EN
      if ((addr % 64'(n)) != 64'd0) begin
         chk("trap_stall", stall_o, 0);
         step();
         chk("trap_misalign", misalign_o, 1);
         chk("trap_no_req", dmem_req, 0);
         chk("trap_wb_en", wb_en_o, 0);
         mem_en_i = 1'b0; wb_en_i = 1'b0; branch_flag_i = 1'b0;
         step();
         chk("trap_pulse_end", misalign_o, 0);
         chk("trap_no_req2", dmem_req, 0);
         return;
      end
`endif
      chk("mem_stall_issue", stall_o, 1);
      stall_cycles = 1;
      step();
      chk("mem_state_busy", dbg_state, 1);
      chk("mem_req", dmem_req, 1);
      chk("mem_we", dmem_we, !load);
      chk("mem_addr", dmem_addr, addr - (addr % 64'd8));
      chk("mem_bubble_wb", wb_en_o, 0);
      chk("mem_bubble_redirect", redirect_o, 0);
      if (!load) begin
         chk("mem_wstrb", dmem_wstrb, exp_strb(addr, p));
         chk("mem_wdata", dmem_wdata, exp_wdata(sv, addr, p));
      end else begin
         exp_q.push_back(exp_load(rdata, addr, p));
      end
      for (int i = 0; i < waits; i++) begin
         if (stall_o) stall_cycles++;
         step();
         chk("mem_req_held", dmem_req, 1);
         chk("mem_wait_wb", wb_en_o, 0);
      end
      dmem_ack = 1'b1; dmem_rdata = rdata;
      #1;
      chk("mem_stall_ack", stall_o, 0);
      step();
      dmem_ack = 1'b0; mem_en_i = 1'b0; wb_en_i = 1'b0; branch_flag_i = 1'b0;
      dmem_rdata = {$urandom(), $urandom()};
      chk("mem_stall_cycles", 64'(stall_cycles), 64'(waits + 1));
      chk("mem_req_drop", dmem_req, 0);
      chk("mem_state_idle", dbg_state, 0);
      if (load) begin
         exp_v = exp_q.pop_front();
         chk("ld_wb_en", wb_en_o, rd != 5'd0);
         if (rd != 5'd0) begin
            chk("ld_wb_rd", wb_rd_o, rd);
            chk("ld_wb_data", wb_data_o, exp_v);
         end
      end else begin
         chk("st_wb_en", wb_en_o, 0);
      end
   endtask

   initial begin
      RST_N = 1'b0; res_i = '0; wb_en_i = 1'b0; rd_i = '0; load_flag_i = 1'b0;
      mem_en_i = 1'b0; mem_para_i = '0; store_value_i = '0; branch_flag_i = 1'b0;
      branch_offset_i = '0; PC_i = '0; dmem_rdata = '0; dmem_ack = 1'b0;
      #12;
      chk("rst_state", dbg_state, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_wdata", dmem_wdata, 0);
      chk("rst_wstrb", dmem_wstrb, 0);
      chk("rst_wb_en", wb_en_o, 0);
      chk("rst_wb_rd", wb_rd_o, 0);
      chk("rst_wb_data", wb_data_o, 0);
      chk("rst_redirect", redirect_o, 0);
      chk("rst_redirect_pc", redirect_pc_o, 0);
      chk("rst_stall", stall_o, 0);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("rst_misalign", misalign_o, 0);
`endif
      @(negedge CLK);
      RST_N = 1'b1;
      step();

      // ALU pass-through and branches
      alu_op(1'b1, 5'd5, 64'h1234, 1'b0, 64'h0, 64'h0);
      alu_op(1'b0, 5'd0, 64'h0, 1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8);
      alu_op(1'b0, 5'd0, 64'h1, 1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("br_pc_const", redirect_pc_o, 64'hF8);
      alu_op(1'b0, 5'd0, 64'h1, 1'b0, 64'h100, 64'h8);
      chk("br_pulse_end", redirect_o, 0);

      // LB sign-extend with three wait cycles
      mem_op(1'b1, 3'd0, 64'h1003, 64'h0, 5'd7, 64'h0000_0000_80FF_0000, 3);
      chk("lb_const", wb_data_o, 64'hFFFF_FFFF_FFFF_FF80);

      // SH into the top lanes
      mem_op(1'b0, 3'd1, 64'h2006, 64'hABCD, 5'd0, 64'h0, 0);

`ifdef MEM_MISALIGN_TRAP_EN
      mem_op(1'b1, 3'd2, 64'h2, 64'h0, 5'd3, 64'h0, 0);
`endif

      // reset while an access is outstanding
      mem_en_i = 1'b1; load_flag_i = 1'b1; mem_para_i = 3'd3; res_i = 64'h3000; rd_i = 5'd9;
      step();
      chk("rstmid_req_before", dmem_req, 1);
      #2;
      RST_N = 1'b0; mem_en_i = 1'b0; wb_en_i = 1'b0;
      #1;
      chk("rstmid_req_drop", dmem_req, 0);
      chk("rstmid_state", dbg_state, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      step();
      step();
      dmem_ack = 1'b1; dmem_rdata = 64'hDEAD_BEEF_0000_1111;
      #1;
      chk("rstmid_late_stall", stall_o, 0);
      step();
      dmem_ack = 1'b0;
      chk("rstmid_no_wb", wb_en_o, 0);
      chk("rstmid_no_req", dmem_req, 0);

      // randomized traffic
      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 2) == 0)
            alu_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom(), $urandom()},
                   1'($urandom_range(0, 1)), {$urandom(), $urandom()}, {$urandom(), $urandom()});
         else
            mem_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom(), $urandom()},
                   {$urandom(), $urandom()}, 5'($urandom_range(0, 31)), {$urandom(), $urandom()},
                   int'($urandom_range(0, 3)));
      end

      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
